// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with write-to-read bypass, busy scoreboard and flush
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  output logic [NREAD-1:0]      rs_busy,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       xd,
  input  logic                  alloc_en,
  input  logic [AW-1:0]         alloc_rd,
  input  logic                  flush,
  output logic [NREGS-1:0]      busy_vec
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy, busy_nxt, wb_mask, al_mask;
  logic we;
  assign we = rd_en && !(ZERO_REG != 0 && rd == '0);
  assign wb_mask = rd_en ? NREGS'(1) << rd : '0;
  assign al_mask = (alloc_en && !(ZERO_REG != 0 && alloc_rd == '0)) ? NREGS'(1) << alloc_rd : '0;
  // a new producer supersedes a same-edge writeback; flush drops every pending producer
  always_comb busy_nxt = flush ? '0 : (busy & ~wb_mask) | al_mask;
  // architectural state and scoreboard
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      busy <= '0;
    end else begin
      if (we) regs[rd] <= xd;
      busy <= busy_nxt;
    end
  end
  assign busy_vec = rst ? '0 : busy;
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic zero, byp;
    assign a = rs_addr[i*AW +: AW];
    assign zero = ZERO_REG != 0 && a == '0;
    assign byp = BYPASS != 0 && rd_en && rd == a;
    assign rs_data[i*XLEN +: XLEN] = (rst || zero) ? '0 : byp ? xd : regs[a];
    assign rs_busy[i] = !(rst || zero || byp) && busy[a];
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: vector table, corner sequences and randomized model check
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [9:0] rs_addr;
  logic rd_en, alloc_en, flush;
  logic [4:0] rd, alloc_rd;
  logic [31:0] xd;
  logic [63:0] a_data, b_data;
  logic [1:0] a_busy, b_busy;
  logic [31:0] a_bv, b_bv;
  logic [15:0] w_addr;
  logic [127:0] w_data;
  logic [3:0] w_busy, w_rd, w_alloc_rd;
  logic w_rd_en, w_alloc_en, w_flush;
  logic [31:0] w_xd;
  logic [15:0] w_bv;
  regfile_scoreboard dut_a (.clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(a_data), .rs_busy(a_busy),
    .rd_en(rd_en), .rd(rd), .xd(xd), .alloc_en(alloc_en), .alloc_rd(alloc_rd), .flush(flush), .busy_vec(a_bv));
  regfile_scoreboard #(.BYPASS(0)) dut_b (.clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_data(b_data), .rs_busy(b_busy),
    .rd_en(rd_en), .rd(rd), .xd(xd), .alloc_en(alloc_en), .alloc_rd(alloc_rd), .flush(flush), .busy_vec(b_bv));
  regfile_scoreboard #(.NREGS(16), .NREAD(4)) dut_w (.clk(clk), .rst(rst), .rs_addr(w_addr), .rs_data(w_data),
    .rs_busy(w_busy), .rd_en(w_rd_en), .rd(w_rd), .xd(w_xd), .alloc_en(w_alloc_en), .alloc_rd(w_alloc_rd),
    .flush(w_flush), .busy_vec(w_bv));
  int chk = 0;
  int err = 0;
  typedef struct {
    int unsigned rd_en, rd, xd, alloc_en, alloc_rd, flush, a0, a1, d0, d1, b0, b1, bv;
  } vec_t;
  vec_t tv[17];
  logic [31:0] mr[32];
  bit mb[32];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle;
    rd_en = 0; rd = 0; xd = 0; alloc_en = 0; alloc_rd = 0; flush = 0;
  endtask
  task automatic model_reset;
    for (int k = 0; k < 32; k++) begin
      mr[k] = 0;
      mb[k] = 0;
    end
  endtask
  initial begin
    idle();
    rs_addr = 0;
    w_addr = 0; w_rd_en = 0; w_rd = 0; w_xd = 0; w_alloc_en = 0; w_alloc_rd = 0; w_flush = 0;
    tv[0]  = '{1, 7, 'h12345678, 0, 0, 0, 7, 7, 'h12345678, 'h12345678, 0, 0, 0};
    tv[1]  = '{0, 0, 0, 0, 0, 0, 7, 7, 'h12345678, 'h12345678, 0, 0, 0};
    tv[2]  = '{1, 0, 'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 7, 0, 'h12345678, 0, 0, 0};
    tv[4]  = '{1, 3, 1, 0, 0, 0, 3, 3, 1, 1, 0, 0, 0};
    tv[5]  = '{1, 3, 'hA5A5A5A5, 0, 0, 0, 3, 7, 'hA5A5A5A5, 'h12345678, 0, 0, 0};
    tv[6]  = '{0, 0, 0, 1, 9, 0, 9, 3, 0, 'hA5A5A5A5, 0, 0, 0};
    tv[7]  = '{0, 0, 0, 0, 0, 0, 9, 3, 0, 'hA5A5A5A5, 1, 0, 'h200};
    tv[8]  = '{1, 9, 'h55, 0, 0, 0, 9, 9, 'h55, 'h55, 0, 0, 'h200};
    tv[9]  = '{0, 0, 0, 0, 0, 0, 9, 9, 'h55, 'h55, 0, 0, 0};
    tv[10] = '{1, 4, 'h77, 1, 4, 0, 4, 9, 'h77, 'h55, 0, 0, 0};
    tv[11] = '{0, 0, 0, 1, 0, 0, 4, 0, 'h77, 0, 1, 0, 'h10};
    tv[12] = '{0, 0, 0, 1, 1, 0, 0, 4, 0, 'h77, 0, 1, 'h10};
    tv[13] = '{0, 0, 0, 1, 2, 0, 1, 4, 0, 'h77, 1, 1, 'h12};
    tv[14] = '{0, 0, 0, 1, 31, 0, 2, 1, 0, 0, 1, 1, 'h16};
    tv[15] = '{1, 2, 'h99, 1, 6, 1, 2, 31, 'h99, 0, 0, 1, 'h80000016};
    tv[16] = '{0, 0, 0, 0, 0, 0, 2, 6, 'h99, 0, 0, 0, 0};
    repeat (2) @(negedge clk);
    rd_en = 1; rd = 5; xd = 32'h0BADF00D; rs_addr = {5'd5, 5'd5};
    #1;
    check("reset data", 64'(a_data), 64'd0);
    check("reset rs_busy", 64'(a_busy), 64'd0);
    check("reset busy_vec", 64'(a_bv), 64'd0);
    @(negedge clk);
    idle();
    rst = 0;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      rd_en = 1'(tv[i].rd_en); rd = 5'(tv[i].rd); xd = tv[i].xd;
      alloc_en = 1'(tv[i].alloc_en); alloc_rd = 5'(tv[i].alloc_rd); flush = 1'(tv[i].flush);
      rs_addr = {5'(tv[i].a1), 5'(tv[i].a0)};
      #1;
      check($sformatf("tv%0d d0", i), 64'(a_data[31:0]), 64'(tv[i].d0));
      check($sformatf("tv%0d d1", i), 64'(a_data[63:32]), 64'(tv[i].d1));
      check($sformatf("tv%0d b0", i), 64'(a_busy[0]), 64'(tv[i].b0));
      check($sformatf("tv%0d b1", i), 64'(a_busy[1]), 64'(tv[i].b1));
      check($sformatf("tv%0d busy_vec", i), 64'(a_bv), 64'(tv[i].bv));
      tick();
    end
    rd_en = 1; rd = 5; xd = 32'hDEADBEEF; alloc_en = 1; alloc_rd = 5;
    tick();
    idle();
    rs_addr = {5'd5, 5'd5};
    #1;
    check("pre-reset x5", 64'(a_data[31:0]), 64'hDEADBEEF);
    check("pre-reset busy5", 64'(a_bv[5]), 64'd1);
    rd_en = 1; rd = 5; xd = 32'h00012345;
    #2 rst = 1;
    #1;
    check("in-reset x5", 64'(a_data[31:0]), 64'd0);
    check("in-reset rs_busy", 64'(a_busy), 64'd0);
    check("in-reset busy_vec", 64'(a_bv), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    idle();
    #1;
    check("post-reset x5", 64'(a_data[31:0]), 64'd0);
    check("post-reset busy_vec", 64'(a_bv), 64'd0);
    @(negedge clk);
    rd_en = 1; rd = 3; xd = 1;
    tick();
    rd_en = 1; rd = 3; xd = 32'hA5A5A5A5; rs_addr = {5'd0, 5'd3};
    #1;
    check("nobyp same cycle", 64'(b_data[31:0]), 64'd1);
    check("nobyp same busy", 64'(b_busy[0]), 64'd0);
    tick();
    idle();
    #1;
    check("nobyp next cycle", 64'(b_data[31:0]), 64'hA5A5A5A5);
    alloc_en = 1; alloc_rd = 3;
    tick();
    idle();
    rd_en = 1; rd = 3; xd = 32'h55;
    #1;
    check("nobyp wb busy", 64'(b_busy[0]), 64'd1);
    check("nobyp wb old", 64'(b_data[31:0]), 64'hA5A5A5A5);
    tick();
    idle();
    #1;
    check("nobyp wb done busy", 64'(b_busy[0]), 64'd0);
    check("nobyp wb done data", 64'(b_data[31:0]), 64'h55);
    for (int k = 1; k < 16; k++) begin
      w_rd_en = 1; w_rd = 4'(k); w_xd = 32'(k) * 32'h01010101;
      tick();
    end
    w_rd_en = 0; w_alloc_en = 1; w_alloc_rd = 5;
    tick();
    w_alloc_rd = 15;
    tick();
    w_alloc_en = 0;
    w_addr = {4'd15, 4'd5, 4'd9, 4'd0};
    #1;
    check("wide p0", 64'(w_data[31:0]), 64'd0);
    check("wide p1", 64'(w_data[63:32]), 64'h09090909);
    check("wide p2", 64'(w_data[95:64]), 64'h05050505);
    check("wide p3", 64'(w_data[127:96]), 64'h0F0F0F0F);
    check("wide rs_busy", 64'(w_busy), 64'b1100);
    check("wide busy_vec", 64'(w_bv), 64'h8020);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      bit sm;
      logic [31:0] ev;
      sm = $urandom_range(0, 1) == 1;
      rd_en = $urandom_range(0, 2) != 0;
      rd = sm ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      xd = $urandom;
      alloc_en = $urandom_range(0, 2) != 0;
      alloc_rd = sm ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      flush = $urandom_range(0, 15) == 0;
      rs_addr = sm ? {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))} : 10'($urandom);
      #1;
      for (int p = 0; p < 2; p++) begin
        int a;
        logic [31:0] ed;
        bit eb;
        a = int'(rs_addr[p*5 +: 5]);
        ed = (a == 0) ? 32'd0 : mr[a];
        eb = (a == 0) ? 1'b0 : mb[a];
        check($sformatf("rnd%0d nb d%0d", n, p), 64'(b_data[p*32 +: 32]), 64'(ed));
        check($sformatf("rnd%0d nb b%0d", n, p), 64'(b_busy[p]), 64'(eb));
        if (a != 0 && rd_en && int'(rd) == a) begin
          ed = xd;
          eb = 0;
        end
        check($sformatf("rnd%0d d%0d", n, p), 64'(a_data[p*32 +: 32]), 64'(ed));
        check($sformatf("rnd%0d b%0d", n, p), 64'(a_busy[p]), 64'(eb));
      end
      ev = 0;
      for (int k = 0; k < 32; k++) ev[k] = mb[k];
      check($sformatf("rnd%0d busy_vec", n), 64'(a_bv), 64'(ev));
      @(posedge clk);
      if (rd_en && rd != 0) mr[rd] = xd;
      if (flush) begin
        for (int k = 0; k < 32; k++) mb[k] = 0;
      end else begin
        if (rd_en) mb[rd] = 0;
        if (alloc_en && alloc_rd != 0) mb[alloc_rd] = 1;
      end
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
